bist_pattern_engine: RTL and testbench

BIST datapath controller paired with the BIST sequencing FSM. It decodes the FSM's 5-bit `BIST_CODE` each cycle and drives the test datapath:
- LFSR pattern generation,
- pattern counting and periodic logic reset of the circuit under test (CUT),
- capture-clock gating,
- response comparison and MISR signature compaction,
- first-error logging.

It returns the decision flags (`end_flag`, `log_res_flag`, `log_clk_en`, `error_flag`, `Counter_in`) that the FSM samples in its branch states.

---
 rtl/bist_pattern_engine.sv | 198 +++++++++++++++++++
 tb/tb_bist_pattern_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_pattern_engine.sv
// bist_pattern_engine
// Datapath half of the BIST controller. Each rising edge of BIST_clk it
// decodes the FSM state code (BIST_CODE) and performs that state's action:
// LFSR pattern generation, pattern counting, periodic CUT logic reset,
// capture-clock pulse, response compare, MISR compaction and first-error
// logging. The decision flags it returns are sampled by the FSM.
//
// Ports
//   BIST_clk, res        clock, async active-high reset
//   BIST_CODE[4:0]       current FSM state code
//   seed[7:0]            LFSR seed (0 maps to 0x01)
//   cut_resp, golden     CUT response and its expected value
//   cut_stim[7:0]        stimulus to the CUT
//   cut_clk_en, cut_rst  one-cycle pulses to the CUT
//   Counter_in[7:0]      pattern index (saturating)
//   end_flag, log_res_flag, log_clk_en, error_flag   flags to the FSM
//   signature[7:0]       MISR contents
//   err_valid, err_addr  first-error record
//   done, pass           run status
module bist_pattern_engine #(
    parameter int N_PAT    = 64,
    parameter int RST_LOG2 = 4
) (
    input  logic       BIST_clk,
    input  logic       res,
    input  logic [4:0] BIST_CODE,
    input  logic [7:0] seed,
    input  logic [7:0] cut_resp,
    input  logic [7:0] golden,
    output logic [7:0] cut_stim,
    output logic       cut_clk_en,
    output logic       cut_rst,
    output logic [7:0] Counter_in,
    output logic       end_flag,
    output logic       log_res_flag,
    output logic       log_clk_en,
    output logic       error_flag,
    output logic [7:0] signature,
    output logic       err_valid,
    output logic [7:0] err_addr,
    output logic       done,
    output logic       pass
);

    localparam logic [4:0] C_START   = 5'd4;
    localparam logic [4:0] C_APPLY   = 5'd5;
    localparam logic [4:0] C_SETTLE  = 5'd6;
    localparam logic [4:0] C_LRST    = 5'd8;
    localparam logic [4:0] C_ADVANCE = 5'd9;
    localparam logic [4:0] C_CAPTURE = 5'd10;
    localparam logic [4:0] C_COMPARE = 5'd11;
    localparam logic [4:0] C_LOG     = 5'd13;
    localparam logic [4:0] C_DONE_A  = 5'd14;
    localparam logic [4:0] C_DONE_B  = 5'd15;
    localparam logic [4:0] C_DONE_C  = 5'd16;

    // Low RST_LOG2 bits of the index; a mask avoids a zero-width slice
    // when logic reset is disabled.
    localparam logic [7:0] RST_MASK = 8'((1 << RST_LOG2) - 1);
    localparam logic [7:0] N_PAT_B  = 8'(N_PAT);
    localparam logic       RST_EN   = (RST_LOG2 != 0);

    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] cut_stim_q, cut_stim_d;
    logic [7:0] pat_cnt_q, pat_cnt_d;
    logic [7:0] sig_q, sig_d;
    logic [7:0] err_addr_q, err_addr_d;
    logic       err_valid_q, err_valid_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       end_q, end_d;
    logic       log_res_q, log_res_d;
    logic       log_clk_q, log_clk_d;
    logic       error_q, error_d;
    logic       cut_rst_q, cut_rst_d;
    logic       cut_clk_en_q, cut_clk_en_d;

    logic [7:0] lfsr_step;
    logic [7:0] misr_step;

    assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign misr_step = {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3]} ^ cut_resp;

    always_comb begin
        lfsr_d       = lfsr_q;
        cut_stim_d   = cut_stim_q;
        pat_cnt_d    = pat_cnt_q;
        sig_d        = sig_q;
        err_addr_d   = err_addr_q;
        err_valid_d  = err_valid_q;
        done_d       = done_q;
        end_d        = end_q;
        log_res_d    = log_res_q;
        log_clk_d    = log_clk_q;
        error_d      = error_q;
        // Pulses drop on the edge after the code that raised them.
        cut_rst_d    = 1'b0;
        cut_clk_en_d = 1'b0;

        case (BIST_CODE)
            C_START: begin
                lfsr_d      = (seed == 8'h00) ? 8'h01 : seed;
                pat_cnt_d   = 8'h00;
                sig_d       = 8'h00;
                err_valid_d = 1'b0;
                err_addr_d  = 8'h00;
                done_d      = 1'b0;
                end_d       = 1'b0;
                log_res_d   = 1'b0;
                log_clk_d   = 1'b0;
                error_d     = 1'b0;
            end
            C_APPLY: cut_stim_d = lfsr_q;
            C_SETTLE: begin
                end_d     = (pat_cnt_q >= N_PAT_B);
                // Index 0 never resets; the final (end) index never resets.
                log_res_d = RST_EN && (pat_cnt_q != 8'h00) &&
                            ((pat_cnt_q & RST_MASK) == 8'h00) && !end_d;
                log_clk_d = !end_d;
            end
            C_LRST: cut_rst_d = 1'b1;
            C_ADVANCE: begin
                if (pat_cnt_q != 8'hFF) pat_cnt_d = pat_cnt_q + 8'd1;
                lfsr_d    = lfsr_step;
                error_d   = 1'b0;
                end_d     = 1'b0;
                log_res_d = 1'b0;
                log_clk_d = 1'b0;
            end
            C_CAPTURE: cut_clk_en_d = 1'b1;
            C_COMPARE: begin
                error_d = (cut_resp != golden);
                sig_d   = misr_step;
            end
            C_LOG: begin
                if (!err_valid_q) begin
                    err_valid_d = 1'b1;
                    err_addr_d  = pat_cnt_q;
                end
            end
            C_DONE_A, C_DONE_B, C_DONE_C: done_d = 1'b1;
            default: ;
        endcase

        // Registered from next-state values so pass tracks done/err_valid
        // in the same cycle.
        pass_d = done_d & ~err_valid_d;
    end

    always_ff @(posedge BIST_clk or posedge res) begin
        if (res) begin
            lfsr_q       <= 8'h01;
            cut_stim_q   <= 8'h00;
            pat_cnt_q    <= 8'h00;
            sig_q        <= 8'h00;
            err_addr_q   <= 8'h00;
            err_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            end_q        <= 1'b0;
            log_res_q    <= 1'b0;
            log_clk_q    <= 1'b0;
            error_q      <= 1'b0;
            cut_rst_q    <= 1'b0;
            cut_clk_en_q <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            cut_stim_q   <= cut_stim_d;
            pat_cnt_q    <= pat_cnt_d;
            sig_q        <= sig_d;
            err_addr_q   <= err_addr_d;
            err_valid_q  <= err_valid_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            end_q        <= end_d;
            log_res_q    <= log_res_d;
            log_clk_q    <= log_clk_d;
            error_q      <= error_d;
            cut_rst_q    <= cut_rst_d;
            cut_clk_en_q <= cut_clk_en_d;
        end
    end

    assign cut_stim     = cut_stim_q;
    assign cut_clk_en   = cut_clk_en_q;
    assign cut_rst      = cut_rst_q;
    assign Counter_in   = pat_cnt_q;
    assign end_flag     = end_q;
    assign log_res_flag = log_res_q;
    assign log_clk_en   = log_clk_q;
    assign error_flag   = error_q;
    assign signature    = sig_q;
    assign err_valid    = err_valid_q;
    assign err_addr     = err_addr_q;
    assign done         = done_q;
    assign pass         = pass_q;

endmodule

// File: tb/tb_bist_pattern_engine.sv
// Bench for bist_pattern_engine (N_PAT=8, RST_LOG2=2). An FSM model drives
// the codes; expectations are queued as each code is driven and checked
// one cycle later, after the edge that registers the code's effect.
module tb_bist_pattern_engine;

    logic       BIST_clk = 1'b0;
    logic       res;
    logic [4:0] BIST_CODE;
    logic [7:0] seed, cut_resp, golden;
    logic [7:0] cut_stim, Counter_in, signature, err_addr;
    logic       cut_clk_en, cut_rst, end_flag, log_res_flag, log_clk_en;
    logic       error_flag, err_valid, done, pass;

    bist_pattern_engine #(.N_PAT(8), .RST_LOG2(2)) dut (
        .BIST_clk(BIST_clk), .res(res), .BIST_CODE(BIST_CODE), .seed(seed),
        .cut_resp(cut_resp), .golden(golden), .cut_stim(cut_stim),
        .cut_clk_en(cut_clk_en), .cut_rst(cut_rst), .Counter_in(Counter_in),
        .end_flag(end_flag), .log_res_flag(log_res_flag), .log_clk_en(log_clk_en),
        .error_flag(error_flag), .signature(signature), .err_valid(err_valid),
        .err_addr(err_addr), .done(done), .pass(pass)
    );

    always #5 BIST_clk = ~BIST_clk;

    localparam int S_STIM = 0, S_CLKEN = 1, S_RST = 2, S_CNT = 3, S_END = 4,
                   S_LOGR = 5, S_LCLK = 6, S_ERR = 7, S_SIG = 8, S_ERRV = 9,
                   S_ADDR = 10, S_DONE = 11, S_PASS = 12;

    int total = 0;
    int bad   = 0;

    string sb_tag[$];
    int    sb_sel[$];
    int    sb_exp[$];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int obs_of(input int sel);
        case (sel)
            S_STIM:  return int'(cut_stim);
            S_CLKEN: return int'(cut_clk_en);
            S_RST:   return int'(cut_rst);
            S_CNT:   return int'(Counter_in);
            S_END:   return int'(end_flag);
            S_LOGR:  return int'(log_res_flag);
            S_LCLK:  return int'(log_clk_en);
            S_ERR:   return int'(error_flag);
            S_SIG:   return int'(signature);
            S_ERRV:  return int'(err_valid);
            S_ADDR:  return int'(err_addr);
            S_DONE:  return int'(done);
            S_PASS:  return int'(pass);
            default: return -1;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int exp);
        sb_tag.push_back(tag);
        sb_sel.push_back(sel);
        sb_exp.push_back(exp);
    endtask

    task automatic drain();
        string t;
        int s, e;
        while (sb_sel.size() > 0) begin
            t = sb_tag.pop_front();
            s = sb_sel.pop_front();
            e = sb_exp.pop_front();
            chk(t, obs_of(s), e);
        end
    endtask

    task automatic cyc(input logic [4:0] code);
        BIST_CODE = code;
        @(posedge BIST_clk);
        #1;
        drain();
    endtask

    task automatic push_all_zero(input string tag);
        for (int s = S_STIM; s <= S_PASS; s++) push(tag, s, 0);
    endtask

    function automatic logic [7:0] lfsr_nx(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] misr_nx(input logic [7:0] v, input logic [7:0] d);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]} ^ d;
    endfunction

    // FSM model. err_idx: index whose response mismatches (-1 none).
    // rst_at: index at which code 4 is re-entered after settle (-1 none).
    task automatic run(input int err_idx, input int rst_at, input logic [7:0] sd);
        int idx, first_err;
        logic [7:0] lm, sm, r, g;
        bit e, lr, errd, fin;
        seed = sd;
        lm = (sd == 8'h00) ? 8'h01 : sd;
        sm = 8'h00;
        idx = 0;
        errd = 0;
        first_err = 0;
        fin = 0;
        push("start_cnt", S_CNT, 0);
        push("start_sig", S_SIG, 0);
        push("start_errv", S_ERRV, 0);
        push("start_done", S_DONE, 0);
        cyc(5'd4);
        while (!fin) begin
            push("stim", S_STIM, int'(lm));
            cyc(5'd5);
            e  = (idx >= 8);
            lr = (idx != 0) && (idx % 4 == 0) && !e;
            push("end_flag", S_END, int'(e));
            push("log_res_flag", S_LOGR, int'(lr));
            push("log_clk_en", S_LCLK, int'(!e));
            push("idx", S_CNT, idx);
            cyc(5'd6);
            if (idx == rst_at) begin
                lm = (sd == 8'h00) ? 8'h01 : sd;
                push("rs_cnt", S_CNT, 0);
                push("rs_sig", S_SIG, 0);
                push("rs_end", S_END, 0);
                push("rs_lclk", S_LCLK, 0);
                push("rs_logr", S_LOGR, 0);
                cyc(5'd4);
                push("rs_stim", S_STIM, int'(lm));
                cyc(5'd5);
                fin = 1;
            end else begin
                cyc(5'd7);
                if (e) begin
                    push("fin_done", S_DONE, 1);
                    push("fin_pass", S_PASS, int'(!errd));
                    push("fin_sig", S_SIG, int'(sm));
                    push("fin_errv", S_ERRV, int'(errd));
                    if (errd) push("fin_addr", S_ADDR, first_err);
                    cyc(5'd15);
                    push("hold_done", S_DONE, 1);
                    cyc(5'd16);
                    fin = 1;
                end else begin
                    if (lr) begin
                        push("cut_rst_hi", S_RST, 1);
                        cyc(5'd8);
                        push("cut_rst_lo", S_RST, 0);
                    end else begin
                        push("clk_en_hi", S_CLKEN, 1);
                        cyc(5'd10);
                        r = 8'($urandom);
                        g = (idx == err_idx) ? (r ^ 8'h5A) : r;
                        cut_resp = r;
                        golden = g;
                        push("clk_en_lo", S_CLKEN, 0);
                        push("error_flag", S_ERR, int'(r != g));
                        cyc(5'd11);
                        sm = misr_nx(sm, r);
                        cyc(5'd12);
                        if (r != g) begin
                            if (!errd) first_err = idx;
                            errd = 1;
                            push("err_valid", S_ERRV, 1);
                            push("err_addr", S_ADDR, first_err);
                            cyc(5'd13);
                        end
                    end
                    idx++;
                    lm = lfsr_nx(lm);
                    push("adv_cnt", S_CNT, idx);
                    push("adv_err", S_ERR, 0);
                    push("adv_end", S_END, 0);
                    cyc(5'd9);
                end
            end
        end
    endtask

    initial begin
        logic [7:0] tbl [5];
        tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        res = 1'b1;
        BIST_CODE = 5'd0;
        seed = 8'h00;
        cut_resp = 8'h00;
        golden = 8'h00;
        #12 res = 1'b0;

        // Reset state holds under a scan code; lfsr reset value shows on apply.
        push_all_zero("rst_hold");
        cyc(5'd0);
        push("rst_lfsr", S_STIM, 8'h01);
        cyc(5'd5);

        // Async reset in the middle of a cycle with a pulse high.
        seed = 8'h5A;
        cyc(5'd4);
        push("seed_stim", S_STIM, 8'h5A);
        cyc(5'd5);
        push("pre_clken", S_CLKEN, 1);
        cyc(5'd10);
        #2 res = 1'b1;
        #1;
        push_all_zero("async_rst");
        drain();
        #2 res = 1'b0;
        push("post_rst_lfsr", S_STIM, 8'h01);
        cyc(5'd5);

        // LFSR sequence from a zero seed.
        seed = 8'h00;
        cyc(5'd4);
        for (int i = 0; i < 5; i++) begin
            push("lfsr_seq", S_STIM, int'(tbl[i]));
            cyc(5'd5);
            cyc(5'd9);
        end

        run(-1, -1, 8'hA7);   // clean run
        run(5, -1, 8'h00);    // mismatch at index 5
        run(-1, 3, 8'hC3);    // restart at index 3

        // Counter saturation.
        cyc(5'd4);
        for (int i = 1; i <= 300; i++) begin
            push("sat_cnt", S_CNT, (i > 255) ? 255 : i);
            cyc(5'd9);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
